store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 25 ++
 rtl/sb_forward_match.sv | 53 +++++
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the store buffer and its forwarding sub-module:
//   default depth/address width, pointer-width helper and the buffered
//   entry record {word address, data}.
//   The word-address field is sized for the widest supported byte address
//   (SB_MAX_AW). Narrower instances zero-extend into it, so the record
//   layout does not depend on the AW parameter of any single instance.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_AW_DEFAULT    = 32;
  localparam int SB_MAX_AW        = 64;
  localparam int SB_WA_W          = SB_MAX_AW - 2;

  typedef struct packed {
    logic [SB_WA_W-1:0] waddr;
    logic [31:0]        data;
  } sb_entry_t;

  // Pointer width for a power-of-two depth; at least one bit.
  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_forward_match.sv
// sb_forward_match
//   Load forwarding for the store buffer. Every slot compares its word
//   address against the load address; among the valid matching slots the
//   youngest one (largest age from head) supplies the data.
// Ports:
//   entries  in   entry storage, indexed by slot
//   head     in   slot index of the oldest buffered store
//   count    in   number of valid entries (0..DEPTH)
//   waddr    in   load word address, zero-extended
//   hit      out  at least one valid entry matched
//   data     out  data of the youngest matching entry (0 when no hit)
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PW    = sb_ptr_w(DEPTH)
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [PW-1:0]      head,
  input  logic [PW:0]        count,
  input  logic [SB_WA_W-1:0] waddr,
  output logic               hit,
  output logic [31:0]        data
);

  logic [DEPTH-1:0] match_vec;

  // A slot is live when its distance from head is below count; DEPTH is a
  // power of two so the subtraction wraps naturally.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [PW-1:0] age;
      assign age           = PW'(gi) - head;
      assign match_vec[gi] = ({1'b0, age} < count) && (entries[gi].waddr == waddr);
    end
  endgenerate

  // Walk oldest to youngest; the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (match_vec[idx]) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Write buffer placed between the core (multicycle_arm) and data_memory.
//   Stores are queued in a circular FIFO and drained to memory in program
//   order whenever memory is ready and no load owns the memory port. Loads
//   go straight to memory but are satisfied from the youngest buffered store
//   to the same word when one exists.
// Ports:
//   clk, Reset            clock, synchronous active-high reset
//   MemWrite, MemRead     core store / load request
//   DataAdr, WriteData    core byte address (bits [1:0] ignored) and store data
//   ReadData              load data back to core (combinational)
//   Stall                 store refused this cycle (buffer full)
//   Empty                 nothing buffered
//   mem_we/addr/wdata     data-memory write port / shared address
//   mem_rdata, mem_ready  data-memory async read data / write accept
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = SB_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] DataAdr,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          Empty,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  // Entry storage carries no reset: validity is defined by count alone.
  sb_entry_t entry_reg [DEPTH];

  logic               full, has_entry;
  logic               load_eff, push, drain;
  logic [SB_WA_W-1:0] req_waddr;
  logic               fwd_hit;
  logic [31:0]        fwd_data;

  assign req_waddr = SB_WA_W'(DataAdr[AW-1:2]);
  assign full      = (count_reg == CW'(DEPTH));
  assign has_entry = (count_reg != '0);

  // A simultaneous store+load is a store; reset masks all requests.
  assign load_eff = MemRead & ~MemWrite & ~Reset;
  assign push     = MemWrite & ~Reset & ~full;
  assign drain    = ~Reset & has_entry & mem_ready & ~load_eff;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (Reset) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push)  tail_next = tail_reg + 1'b1;
      if (drain) head_next = head_reg + 1'b1;
      count_next = count_reg + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[tail_reg] <= '{waddr: req_waddr, data: WriteData};
    end
  end

  sb_forward_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries (entry_reg),
    .head    (head_reg),
    .count   (count_reg),
    .waddr   (req_waddr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  // A load owns the memory address; otherwise it points at the head entry.
  assign mem_we    = drain;
  assign mem_addr  = load_eff  ? DataAdr :
                     has_entry ? {entry_reg[head_reg].waddr[AW-3:0], 2'b00} : '0;
  assign mem_wdata = entry_reg[head_reg].data;
  assign ReadData  = (load_eff && fwd_hit) ? fwd_data : mem_rdata;
  assign Stall     = MemWrite & ~Reset & full;
  assign Empty     = Reset | ~has_entry;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          Reset, MemWrite, MemRead, mem_ready;
  logic [AW-1:0] DataAdr, mem_addr;
  logic [31:0]   WriteData, ReadData, mem_wdata, mem_rdata;
  logic          Stall, Empty, mem_we;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];        // behavioural buffer contents, oldest first
  logic [63:0] wr_log[$];   // {addr, data} of every observed memory write

  always #5 clk = ~clk;

  // Asynchronous memory read: a recognisable function of the address.
  assign mem_rdata = mem_addr ^ KEY;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s t=%0t got=0x%08h expected=0x%08h", name, $time, act, exp);
    end
  endtask

  // Model compare: outputs derived from the queue and the current inputs,
  // then the queue is advanced by what the coming edge must do.
  always @(negedge clk) begin : model
    int          n;
    bit          ld, psh, drn, hit;
    logic [31:0] ea, erd;
    n   = q.size();
    ld  = MemRead && !MemWrite && !Reset;
    psh = MemWrite && !Reset && (n < DEPTH);
    drn = !Reset && (n > 0) && mem_ready && !ld;
    check("m_stall", {31'b0, Stall},  {31'b0, MemWrite && !Reset && (n == DEPTH)});
    check("m_we",    {31'b0, mem_we}, {31'b0, drn});
    check("m_empty", {31'b0, Empty},  {31'b0, Reset || (n == 0)});
    if (!Reset) begin
      ea  = ld ? DataAdr : ((n > 0) ? {q[0].adr[31:2], 2'b00} : 32'h0);
      erd = ea ^ KEY;
      hit = 1'b0;
      if (ld) begin
        for (int i = n - 1; i >= 0 && !hit; i--) begin
          if (q[i].adr[31:2] == DataAdr[31:2]) begin
            erd = q[i].data;
            hit = 1'b1;
          end
        end
      end
      check("m_addr",  mem_addr, ea);
      check("m_rdata", ReadData, erd);
    end
    if (drn) check("m_wdata", mem_wdata, q[0].data);
    if (mem_we === 1'b1) wr_log.push_back({mem_addr, mem_wdata});
    if (Reset) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (psh) q.push_back('{adr: DataAdr, data: WriteData});
    end
  end

  // One bus cycle: drive after the rising edge, return just after the
  // falling edge when outputs have settled and the model has compared.
  task automatic cyc(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                     input bit rdy, input bit rst = 1'b0);
    @(posedge clk);
    #1;
    MemWrite  = w;
    MemRead   = r;
    DataAdr   = a;
    WriteData = d;
    mem_ready = rdy;
    Reset     = rst;
    @(negedge clk);
    #1;
  endtask

  // Idle with memory ready until empty; returns the number of writes seen.
  task automatic drain_all(output int writes);
    int c;
    writes = 0;
    c = 0;
    while (!Empty && c < 40) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      if (mem_we) writes++;
      c++;
    end
    check("drain_timeout", {31'b0, Empty}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          base, wr;
    logic [63:0] exp_list[$];

    Reset = 1'b1; MemWrite = 1'b1; MemRead = 1'b0;
    DataAdr = 32'h40; WriteData = 32'h55; mem_ready = 1'b1;

    // Reset: requests ignored, outputs forced quiet.
    @(negedge clk); #1;
    check("rst_stall", {31'b0, Stall},  32'd0);
    check("rst_we",    {31'b0, mem_we}, 32'd0);
    check("rst_empty", {31'b0, Empty},  32'd1);
    cyc(1'b1, 1'b0, 32'h40, 32'h55, 1'b1, 1'b1);
    check("rst2_empty", {31'b0, Empty}, 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("post_rst_empty", {31'b0, Empty}, 32'd1);
    check("post_rst_addr",  mem_addr,       32'h0);

    // Single store reaches memory in the following cycle.
    cyc(1'b1, 1'b0, 32'h64, 32'h7, 1'b1);
    check("t1_we_n",    {31'b0, mem_we}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t1_we_n1",   {31'b0, mem_we}, 32'd1);
    check("t1_addr_n1", mem_addr,        32'h64);
    check("t1_data_n1", mem_wdata,       32'h7);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t1_empty_n2", {31'b0, Empty}, 32'd1);
    check("t1_we_n2",    {31'b0, mem_we}, 32'd0);

    // Fill with memory stalled, fifth store held until a slot frees.
    base = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'(4 * i), 32'h100 + 32'(i), 1'b0);
      check("t2_accept", {31'b0, Stall}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'h10, 32'h104, 1'b0);
    check("t2_stall_a", {31'b0, Stall}, 32'd1);
    cyc(1'b1, 1'b0, 32'h10, 32'h104, 1'b0);
    check("t2_stall_b", {31'b0, Stall}, 32'd1);
    cyc(1'b1, 1'b0, 32'h10, 32'h104, 1'b1);
    check("t2_stall_drain", {31'b0, Stall},  32'd1);
    check("t2_we_drain",    {31'b0, mem_we}, 32'd1);
    check("t2_addr_drain",  mem_addr,        32'h0);
    cyc(1'b1, 1'b0, 32'h10, 32'h104, 1'b1);
    check("t2_accept5", {31'b0, Stall}, 32'd0);
    drain_all(wr);
    check("t2_count", 32'(wr_log.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < wr_log.size(); i++) begin
      check("t2_order_addr", wr_log[base + i][63:32], 32'(4 * i));
      check("t2_order_data", wr_log[base + i][31:0],  32'h100 + 32'(i));
    end

    // Forwarding from the youngest match; miss goes to memory.
    cyc(1'b1, 1'b0, 32'h20, 32'h11, 1'b0);
    cyc(1'b1, 1'b0, 32'h20, 32'h22, 1'b0);
    cyc(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    check("t3_fwd",  ReadData, 32'h22);
    cyc(1'b0, 1'b1, 32'h24, 32'h0, 1'b0);
    check("t3_miss", ReadData, 32'hDEAD_0024);
    // Load blocks drain even with memory ready.
    cyc(1'b0, 1'b1, 32'h24, 32'h0, 1'b1);
    check("t4_we_load",   {31'b0, mem_we}, 32'd0);
    check("t4_addr_load", mem_addr,        32'h24);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t4_we_a",   {31'b0, mem_we}, 32'd1);
    check("t4_addr_a", mem_addr,        32'h20);
    check("t4_data_a", mem_wdata,       32'h11);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t4_data_b", mem_wdata,       32'h22);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t4_empty",  {31'b0, Empty},  32'd1);

    // Steady push+drain at DEPTH-1 occupancy across several wraps.
    base = wr_log.size();
    exp_list.delete();
    for (int i = 0; i < DEPTH - 1; i++) begin
      cyc(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
      exp_list.push_back({32'h200 + 32'(4 * i), 32'hA0 + 32'(i)});
    end
    for (int j = 0; j < 3 * DEPTH; j++) begin
      cyc(1'b1, 1'b0, 32'h240 + 32'(4 * j), 32'hB0 + 32'(j), 1'b1);
      check("t5_nostall", {31'b0, Stall},  32'd0);
      check("t5_we",      {31'b0, mem_we}, 32'd1);
      exp_list.push_back({32'h240 + 32'(4 * j), 32'hB0 + 32'(j)});
    end
    drain_all(wr);
    check("t5_residual", 32'(wr), 32'(DEPTH - 1));
    check("t5_total", 32'(wr_log.size() - base), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && base + i < wr_log.size(); i++) begin
      check("t5_seq_addr", wr_log[base + i][63:32], exp_list[i][63:32]);
      check("t5_seq_data", wr_log[base + i][31:0],  exp_list[i][31:0]);
    end

    // Reset with three entries while memory would accept a drain.
    base = wr_log.size();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
    check("t6_pre_empty", {31'b0, Empty}, 32'd0);
    cyc(1'b1, 1'b0, 32'h500, 32'h99, 1'b1, 1'b1);
    check("t6_rst_we",    {31'b0, mem_we}, 32'd0);
    check("t6_rst_empty", {31'b0, Empty},  32'd1);
    check("t6_rst_stall", {31'b0, Stall},  32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_after_empty", {31'b0, Empty},  32'd1);
    check("t6_after_we",    {31'b0, mem_we}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_no_writes", 32'(wr_log.size() - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
